// File: rtl/turn_scheduler.sv
// Per-turn sequencer: wind request, timed aim window, charge cap, flight watchdog and
// settle delay, shared by both throw paths. All outputs are registered.
module turn_scheduler #(
  parameter int unsigned TICK_DIV  = 65000,
  parameter int unsigned AIM_MS    = 10000,
  parameter int unsigned CHARGE_MS = 3000,
  parameter int unsigned FLIGHT_MS = 5000,
  parameter int unsigned SETTLE_MS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_active,
  input  logic        dog_turn,
  input  logic        cat_turn,
  input  logic        space_dog,
  input  logic        space_cat,
  input  logic        throw_done,
  output logic        wind_update,
  output logic        charging_dog,
  output logic        charging_cat,
  output logic        throw_enable_dog,
  output logic        throw_enable_cat,
  output logic        next_turn,
  output logic        forced_throw,
  output logic        flight_abort,
  output logic [15:0] ms_left
);

  localparam logic [15:0] TickLast  = 16'(TICK_DIV - 1);
  localparam logic [15:0] AimCnt    = 16'(AIM_MS);
  localparam logic [15:0] ChargeCnt = 16'(CHARGE_MS);
  localparam logic [15:0] FlightCnt = 16'(FLIGHT_MS);
  localparam logic [15:0] SettleCnt = 16'(SETTLE_MS);

  typedef enum logic [2:0] {StIdle, StWind, StAim, StCharge, StFlight, StSettle} state_e;

  state_e      state_q;
  logic        side_q;       // 0 = dog, 1 = cat
  logic        last_side_q;
  logic        served_q;
  logic        armed_q;      // key has been seen low this turn, so a high level is a fresh press
  logic [15:0] presc_q;
  logic [15:0] cnt_q;

  logic        space_sel;
  logic        tick;
  logic        expire;
  logic [15:0] cnt_dec;

  // Side steering and timebase decode.
  always_comb begin
    space_sel = side_q ? space_cat : space_dog;
    tick      = (presc_q == TickLast);
    expire    = tick && (cnt_q == 16'd1);
    cnt_dec   = (tick && (cnt_q != 16'd0)) ? cnt_q - 16'd1 : cnt_q;
  end

  // Turn FSM with registered outputs; every state entry clears the prescaler and loads the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      side_q           <= 1'b0;
      last_side_q      <= 1'b0;
      served_q         <= 1'b0;
      armed_q          <= 1'b0;
      presc_q          <= 16'd0;
      cnt_q            <= 16'd0;
      wind_update      <= 1'b0;
      charging_dog     <= 1'b0;
      charging_cat     <= 1'b0;
      throw_enable_dog <= 1'b0;
      throw_enable_cat <= 1'b0;
      next_turn        <= 1'b0;
      forced_throw     <= 1'b0;
      flight_abort     <= 1'b0;
      ms_left          <= 16'd0;
    end else begin
      wind_update      <= 1'b0;
      throw_enable_dog <= 1'b0;
      throw_enable_cat <= 1'b0;
      next_turn        <= 1'b0;
      presc_q          <= tick ? 16'd0 : presc_q + 16'd1;
      cnt_q            <= cnt_dec;
      if (!game_active) begin
        // Abort wins over everything, including a launch due this cycle.
        state_q      <= StIdle;
        served_q     <= 1'b0;
        last_side_q  <= 1'b0;
        armed_q      <= 1'b0;
        presc_q      <= 16'd0;
        cnt_q        <= 16'd0;
        charging_dog <= 1'b0;
        charging_cat <= 1'b0;
        forced_throw <= 1'b0;
        flight_abort <= 1'b0;
        ms_left      <= 16'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            presc_q <= 16'd0;
            cnt_q   <= 16'd0;
            if ((dog_turn ^ cat_turn) && (!served_q || (cat_turn != last_side_q))) begin
              side_q      <= cat_turn;
              wind_update <= 1'b1;
              state_q     <= StWind;
            end
          end
          StWind: begin
            armed_q <= !space_sel;
            presc_q <= 16'd0;
            cnt_q   <= AimCnt;
            ms_left <= AimCnt;
            state_q <= StAim;
          end
          StAim: begin
            // A press in the expiry cycle still goes to CHARGE.
            if (armed_q && space_sel) begin
              charging_dog <= !side_q;
              charging_cat <= side_q;
              presc_q      <= 16'd0;
              cnt_q        <= ChargeCnt;
              ms_left      <= ChargeCnt;
              state_q      <= StCharge;
            end else if (expire) begin
              throw_enable_dog <= !side_q;
              throw_enable_cat <= side_q;
              forced_throw     <= 1'b1;
              presc_q          <= 16'd0;
              cnt_q            <= FlightCnt;
              ms_left          <= 16'd0;
              state_q          <= StFlight;
            end else begin
              if (!space_sel) armed_q <= 1'b1;
              ms_left <= cnt_dec;
            end
          end
          StCharge: begin
            if (!space_sel || expire) begin
              charging_dog     <= 1'b0;
              charging_cat     <= 1'b0;
              throw_enable_dog <= !side_q;
              throw_enable_cat <= side_q;
              presc_q          <= 16'd0;
              cnt_q            <= FlightCnt;
              ms_left          <= 16'd0;
              state_q          <= StFlight;
            end else begin
              ms_left <= cnt_dec;
            end
          end
          StFlight: begin
            // Landing takes priority over a simultaneous watchdog expiry.
            if (throw_done || expire) begin
              flight_abort <= !throw_done;
              presc_q      <= 16'd0;
              cnt_q        <= SettleCnt;
              ms_left      <= SettleCnt;
              state_q      <= StSettle;
            end
          end
          StSettle: begin
            if (expire) begin
              next_turn    <= 1'b1;
              last_side_q  <= side_q;
              served_q     <= 1'b1;
              forced_throw <= 1'b0;
              flight_abort <= 1'b0;
              presc_q      <= 16'd0;
              cnt_q        <= 16'd0;
              ms_left      <= 16'd0;
              state_q      <= StIdle;
            end else begin
              ms_left <= cnt_dec;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: reset check, vector table, directed turn scenarios and a
// randomized run against a phase/elapsed-time reference model.
module tb_turn_scheduler;

  localparam int TD = 4, AIM = 10, CHG = 6, FLT = 8, STL = 3;
  localparam int PIdle = 0, PWind = 1, PAim = 2, PCharge = 3, PFlight = 4, PSettle = 5;
  localparam int SWind = 0, STeDog = 1, STeCat = 2, SNext = 3, SAbort = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic game_active = 1'b0, dog_turn = 1'b0, cat_turn = 1'b0;
  logic space_dog = 1'b0, space_cat = 1'b0, throw_done = 1'b0;
  logic wind_update, charging_dog, charging_cat, throw_enable_dog, throw_enable_cat;
  logic next_turn, forced_throw, flight_abort;
  logic [15:0] ms_left;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_wind, n_ted, n_tec, n_next, n_chg_dog;

  always #5 clk = ~clk;

  turn_scheduler #(
    .TICK_DIV (TD),
    .AIM_MS   (AIM),
    .CHARGE_MS(CHG),
    .FLIGHT_MS(FLT),
    .SETTLE_MS(STL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .game_active     (game_active),
    .dog_turn        (dog_turn),
    .cat_turn        (cat_turn),
    .space_dog       (space_dog),
    .space_cat       (space_cat),
    .throw_done      (throw_done),
    .wind_update     (wind_update),
    .charging_dog    (charging_dog),
    .charging_cat    (charging_cat),
    .throw_enable_dog(throw_enable_dog),
    .throw_enable_cat(throw_enable_cat),
    .next_turn       (next_turn),
    .forced_throw    (forced_throw),
    .flight_abort    (flight_abort),
    .ms_left         (ms_left)
  );

  wire [7:0] dut_vec = {wind_update, charging_dog, charging_cat, throw_enable_dog,
                        throw_enable_cat, next_turn, forced_throw, flight_abort};

  // Reference model: current phase plus clock edges elapsed since entering it.
  int m_phase, m_t;
  bit m_side, m_key_ok, m_last, m_served, m_forced, m_abort;
  bit m_wind, m_ted, m_tec, m_next;

  function automatic int span(input int p);
    case (p)
      PAim:    return AIM;
      PCharge: return CHG;
      PFlight: return FLT;
      PSettle: return STL;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] m_vec();
    return {m_wind, (m_phase == PCharge) && !m_side, (m_phase == PCharge) && m_side,
            m_ted, m_tec, m_next, m_forced, m_abort};
  endfunction

  function automatic logic [15:0] m_ms();
    if (m_phase == PAim || m_phase == PCharge || m_phase == PSettle)
      return 16'(span(m_phase) - m_t / TD);
    return 16'd0;
  endfunction

  task automatic enter(input int p);
    m_phase = p;
    m_t = 0;
  endtask

  task automatic launch();
    m_ted = !m_side;
    m_tec = m_side;
  endtask

  task automatic model_reset();
    enter(PIdle);
    m_side = 0; m_key_ok = 0; m_last = 0; m_served = 0; m_forced = 0; m_abort = 0;
    m_wind = 0; m_ted = 0; m_tec = 0; m_next = 0;
  endtask

  task automatic model_edge();
    bit sel, expired;
    sel = m_side ? space_cat : space_dog;
    expired = (span(m_phase) != 0) && (m_t + 1 == span(m_phase) * TD);
    m_wind = 0; m_ted = 0; m_tec = 0; m_next = 0;
    if (!game_active) begin
      enter(PIdle);
      m_served = 0; m_last = 0; m_forced = 0; m_abort = 0;
    end else begin
      case (m_phase)
        PIdle:
          if ((dog_turn != cat_turn) && (!m_served || cat_turn != m_last)) begin
            m_side = cat_turn;
            m_wind = 1;
            enter(PWind);
          end
        PWind: begin
          m_key_ok = !sel;
          enter(PAim);
        end
        PAim:
          if (m_key_ok && sel) enter(PCharge);
          else if (expired) begin
            launch();
            m_forced = 1;
            enter(PFlight);
          end else begin
            if (!sel) m_key_ok = 1;
            m_t++;
          end
        PCharge:
          if (!sel || expired) begin
            launch();
            enter(PFlight);
          end else m_t++;
        PFlight:
          if (throw_done) enter(PSettle);
          else if (expired) begin
            m_abort = 1;
            enter(PSettle);
          end else m_t++;
        PSettle:
          if (expired) begin
            m_next = 1;
            m_last = m_side;
            m_served = 1;
            m_forced = 0;
            m_abort = 0;
            enter(PIdle);
          end else m_t++;
        default: enter(PIdle);
      endcase
    end
  endtask

  function automatic logic sig_of(input int s);
    case (s)
      SWind:   return wind_update;
      STeDog:  return throw_enable_dog;
      STeCat:  return throw_enable_cat;
      SNext:   return next_turn;
      SAbort:  return flight_abort;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_tally();
    n_wind = 0; n_ted = 0; n_tec = 0; n_next = 0; n_chg_dog = 0;
  endtask

  // One clock: advance the model on the edge, compare every output 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    checks++;
    if ({dut_vec, ms_left} !== {m_vec(), m_ms()}) begin
      errors++;
      $display("FAIL model cyc=%0d: got vec=%b ms=%0d, expected vec=%b ms=%0d",
               cyc, dut_vec, ms_left, m_vec(), m_ms());
    end
    if (wind_update) n_wind++;
    if (throw_enable_dog) n_ted++;
    if (throw_enable_cat) n_tec++;
    if (next_turn) n_next++;
    if (charging_dog) n_chg_dog++;
    cyc++;
  endtask

  task automatic run_until(input int s, input int max, input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sig_of(s) && n < max);
    if (!sig_of(s)) begin
      checks++;
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, max);
    end
  endtask

  task automatic new_game();
    game_active = 0; dog_turn = 0; cat_turn = 0;
    space_dog = 0; space_cat = 0; throw_done = 0;
    step();
    step();
    game_active = 1;
  endtask

  task automatic land_and_settle(input string name);
    int n;
    throw_done = 1;
    step();
    throw_done = 0;
    run_until(SNext, 30, name, n);
    check(name, n, 12);
  endtask

  typedef struct {
    logic        ga, dt, ct, sd, sc, done;
    int          hold;
    logic [7:0]  vec;
    logic [15:0] ms;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int n;
    logic [1:0] r;

    // {ga, dt, ct, sd, sc, done, hold cycles, expected vec, expected ms_left}
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 3,  8'h00, 16'd0};   // both turns: stay idle
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 2,  8'h00, 16'd0};   // no turn
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 2,  8'h00, 16'd0};   // game inactive
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 1,  8'h80, 16'd0};   // start -> wind pulse
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 1,  8'h00, 16'd10};  // AIM entry
    tbl[5]  = '{1, 1, 0, 0, 0, 0, 4,  8'h00, 16'd9};   // one tick
    tbl[6]  = '{1, 1, 0, 1, 0, 0, 1,  8'h40, 16'd6};   // press -> CHARGE
    tbl[7]  = '{1, 1, 0, 1, 0, 0, 8,  8'h40, 16'd4};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 1,  8'h10, 16'd0};   // release -> launch
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 5,  8'h00, 16'd0};   // in flight
    tbl[10] = '{1, 1, 0, 0, 0, 1, 1,  8'h00, 16'd3};   // landing -> SETTLE
    tbl[11] = '{1, 1, 0, 0, 0, 0, 11, 8'h00, 16'd1};
    tbl[12] = '{1, 1, 0, 0, 0, 0, 1,  8'h04, 16'd0};   // next_turn
    tbl[13] = '{1, 1, 0, 0, 0, 0, 5,  8'h00, 16'd0};   // same side already served

    // Reset
    repeat (3) step();
    check("reset vec", int'(dut_vec), 0);
    check("reset ms_left", int'(ms_left), 0);
    @(negedge clk);
    rst = 1;

    // Vector table
    for (int i = 0; i < 14; i++) begin
      game_active = tbl[i].ga; dog_turn = tbl[i].dt; cat_turn = tbl[i].ct;
      space_dog = tbl[i].sd; space_cat = tbl[i].sc; throw_done = tbl[i].done;
      repeat (tbl[i].hold) step();
      check($sformatf("tbl[%0d] vec", i), int'(dut_vec), int'(tbl[i].vec));
      check($sformatf("tbl[%0d] ms_left", i), int'(ms_left), int'(tbl[i].ms));
    end

    // Normal dog turn
    new_game();
    clear_tally();
    dog_turn = 1;
    step();
    check("normal wind", int'(wind_update), 1);
    repeat (10) step();
    space_dog = 1;
    repeat (12) step();
    space_dog = 0;
    run_until(STeDog, 10, "normal launch", n);
    check("normal launch latency", n, 1);
    check("normal charge cycles", n_chg_dog, 12);
    check("normal forced", int'(forced_throw), 0);
    repeat (4) step();
    land_and_settle("normal next_turn delay");
    check("normal wind count", n_wind, 1);
    check("normal dog launches", n_ted, 1);
    check("normal cat launches", n_tec, 0);
    repeat (10) step();
    check("normal no second turn", n_wind, 1);

    // Idle timeout on cat
    new_game();
    clear_tally();
    cat_turn = 1;
    step();
    step();
    run_until(STeCat, 60, "timeout launch", n);
    check("timeout launch delay", n, 40);
    check("timeout forced", int'(forced_throw), 1);
    check("timeout dog launches", n_ted, 0);
    land_and_settle("timeout next_turn delay");
    check("timeout forced cleared", int'(forced_throw), 0);

    // Held key: no charge, forced launch; later turn with fresh press charges
    new_game();
    clear_tally();
    space_dog = 1;
    step();
    dog_turn = 1;
    step();
    step();
    run_until(STeDog, 60, "held launch", n);
    check("held launch delay", n, 40);
    check("held charge cycles", n_chg_dog, 0);
    check("held forced", int'(forced_throw), 1);
    land_and_settle("held next_turn delay");
    space_dog = 0; dog_turn = 0; cat_turn = 1;
    step();
    step();
    space_cat = 1;
    step();
    space_cat = 0;
    step();
    land_and_settle("cat between next_turn delay");
    clear_tally();
    cat_turn = 0; dog_turn = 1;
    repeat (5) step();
    space_dog = 1;
    repeat (5) step();
    space_dog = 0;
    run_until(STeDog, 10, "repress launch", n);
    check("repress charge cycles", n_chg_dog, 5);
    check("repress forced", int'(forced_throw), 0);
    land_and_settle("repress next_turn delay");

    // Charge cap on cat
    new_game();
    cat_turn = 1;
    repeat (4) step();
    space_cat = 1;
    step();
    check("cap charging entry", int'(charging_cat), 1);
    run_until(STeCat, 40, "cap launch", n);
    check("cap launch delay", n, 24);
    check("cap charging drop", int'(charging_cat), 0);
    check("cap forced", int'(forced_throw), 0);
    land_and_settle("cap next_turn delay");

    // Watchdog
    new_game();
    clear_tally();
    dog_turn = 1;
    step();
    step();
    space_dog = 1;
    step();
    space_dog = 0;
    step();
    check("wd launch", int'(throw_enable_dog), 1);
    run_until(SAbort, 50, "wd abort", n);
    check("wd abort delay", n, 32);
    run_until(SNext, 30, "wd next", n);
    check("wd next_turn delay", n, 12);
    clear_tally();
    repeat (20) step();
    check("wd no second turn", n_wind, 0);

    // Abort mid-CHARGE, then the same side as last served may start again
    dog_turn = 0; cat_turn = 1;
    step();
    step();
    space_cat = 1;
    step();
    repeat (3) step();
    game_active = 0;
    step();
    check("abort vec", int'(dut_vec), 0);
    check("abort ms_left", int'(ms_left), 0);
    clear_tally();
    repeat (5) step();
    check("abort no launch", n_tec, 0);
    check("abort no next_turn", n_next, 0);
    space_cat = 0; cat_turn = 0; dog_turn = 1; game_active = 1;
    step();
    check("abort restart wind", int'(wind_update), 1);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if (game_active) begin
        if ($urandom_range(299) == 0) game_active = 0;
      end else if ($urandom_range(4) == 0) game_active = 1;
      if ($urandom_range(39) == 0) begin
        r = 2'($urandom_range(3));
        dog_turn = r[0];
        cat_turn = r[1];
      end
      if ($urandom_range(7) == 0) space_dog = !space_dog;
      if ($urandom_range(7) == 0) space_cat = !space_cat;
      throw_done = ($urandom_range(24) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Per-turn sequencer sitting between `game_fsm` and the two throw paths (`throw_ctl_dog`/`throw_ctl_cat`). When a turn is granted it:
- requests a fresh wind value;
- opens a timed aim window;
- forces a throw if the player idles;
- waits for the projectile to land, with a watchdog;
- holds a settle delay, then emits `next_turn`.

It replaces ad-hoc `throw_enable` generation, so both sides share one timing policy.

## Interface
Parameters:
- `TICK_DIV`, 65000, clk cycles per timebase tick (1 ms at 65 MHz).
- `AIM_MS`, 10000, aim window length in ticks.
- `CHARGE_MS`, 3000, maximum charge hold before auto-release.
- `FLIGHT_MS`, 5000, watchdog for `throw_done`.
- `SETTLE_MS`, 500, post-landing delay before `next_turn`.

Ports:
- `clk`  in  1  system clock (clk65MHz domain).
- `rst`  in  1  reset; asynchronous, active-low.
- `game_active`  in  1  level; game in play.
- `dog_turn`  in  1  level from game_fsm.
- `cat_turn`  in  1  level from game_fsm.
- `space_dog`  in  1  local charge key, level, already synchronous.
- `space_cat`  in  1  remote charge key, level, already synchronous.
- `throw_done`  in  1  1-cycle pulse from the active throw_ctl.
- `wind_update`  out  1  1-cycle pulse requesting new wind.
- `charging_dog`  out  1  level; dog force bar enable.
- `charging_cat`  out  1  level; cat force bar enable.
- `throw_enable_dog`  out  1  1-cycle launch pulse.
- `throw_enable_cat`  out  1  1-cycle launch pulse.
- `next_turn`  out  1  1-cycle pulse.
- `forced_throw`  out  1  level; the current turn was launched by a timeout. Cleared in IDLE.
- `flight_abort`  out  1  level; the watchdog expired this turn. Cleared in IDLE.
- `ms_left`  out  16  remaining ticks of the current timed state; 0 in IDLE, WIND and FLIGHT.

## Operation
- Side select: `side` is latched at turn start (0 = dog, 1 = cat). `space_sel`, `charging_*` and `throw_enable_*` are all steered by `side`.
- Timebase:
  - The prescaler clears on every state entry and emits `tick` every `TICK_DIV` cycles.
  - The state counter loads N on entry and decrements on `tick`.
  - The state expires on the tick that takes the counter to 0, exactly N·`TICK_DIV` cycles after entry.
- `last_side` and `served` flags:
  - Cleared while `game_active`=0.
  - Written on leaving SETTLE.
- States:
  - IDLE: all outputs 0.
    - Start condition: `game_active` & (`dog_turn` XOR `cat_turn`) & (!`served` | new side ≠ `last_side`).
    - On start: latch `side`, go to WIND.
    - Both turns high, or neither: stay in IDLE.
  - WIND: `wind_update`=1 for one cycle, then AIM with counter=`AIM_MS`.
    - If `space_sel` is already high on entry, it must fall before a press is recognised, so a held key does not auto-charge.
  - AIM:
    - Rising edge of `space_sel` → CHARGE, counter=`CHARGE_MS`.
    - Expiry → launch pulse, `forced_throw`=1, go to FLIGHT.
  - CHARGE: `charging_side`=1.
    - `space_sel` low, or expiry → launch pulse, `charging` drops in the same cycle, go to FLIGHT.
  - FLIGHT: wait for `throw_done`.
    - `throw_done` → SETTLE, counter=`SETTLE_MS`.
    - Watchdog (`FLIGHT_MS`) expiry → `flight_abort`=1, go to SETTLE.
    - `throw_done` arriving in any other state is ignored.
  - SETTLE:
    - Expiry → `next_turn`=1 for one cycle, `last_side`←`side`, `served`←1, go to IDLE.
- Abort: `game_active`=0 in any state → IDLE on the next edge.
  - All outputs are 0 from that cycle on.
  - No `next_turn` is emitted.
  - No launch pulse is emitted, even if the abort lands on the launch cycle.
- Simultaneity:
  - Expiry and release in the same cycle in CHARGE → one launch, `forced_throw` stays 0.
  - Expiry and `throw_done` in the same cycle in FLIGHT → treated as landing; `flight_abort` stays 0.
- Widths: counters are 16 bits; parameters must be < 65536.

## Timing
- Reset (`rst`=0): state=IDLE, all outputs 0, prescaler 0, counters 0, `served` 0.
- All outputs are registered.
- IDLE→WIND takes one cycle after the start condition.
- `wind_update` is asserted in the cycle after the start condition is seen.
- The launch pulse is asserted one cycle after the release edge is sampled.
- `next_turn` rises exactly `SETTLE_MS`·`TICK_DIV` cycles after `throw_done` is sampled.

## Test plan
Test parameters: `TICK_DIV`=4, `AIM_MS`=10, `CHARGE_MS`=6, `FLIGHT_MS`=8, `SETTLE_MS`=3.
- Normal dog turn: `game_active`=1, `dog_turn`=1, press `space_dog` 10 cycles after `wind_update`, release after 12 cycles, `throw_done` 5 cycles later → `wind_update` once, `charging_dog` high 12 cycles, one `throw_enable_dog`, `next_turn` 12 cycles after `throw_done`, `forced_throw`=0.
- Idle timeout on cat: `cat_turn`=1, no key → `throw_enable_cat` 40 cycles after AIM entry, `forced_throw`=1; no `throw_enable_dog` at any time.
- Held key: `space_dog` high before the turn and kept high → no CHARGE and a forced launch at 40 cycles. After release and re-press in a later turn → normal charge.
- Charge cap: hold `space_cat` indefinitely → launch 24 cycles after CHARGE entry, `charging_cat` falls in the same cycle.
- Watchdog: never pulse `throw_done` → `flight_abort`=1 after 32 cycles, `next_turn` 12 cycles later. Holding `dog_turn` high afterwards → no second turn.
- Abort mid-CHARGE: drop `game_active` → all outputs 0 next cycle, no launch, no `next_turn`. Reassert `game_active` with `dog_turn`=1 → a new turn starts (`served` cleared).
